// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: combinational or shift-add multiply and a
// radix-2 restoring divider on operand magnitudes, with sign correction at the end.
module ex_muldiv #(
    parameter int XLEN     = 32,
    parameter int MUL_ITER = 0,
    parameter int CNT_W    = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_adr_in,
    input  logic            kill,
    input  logic            hold,
    output logic            busy,
    output logic            res_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_adr_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [XLEN-1:0]  acc_hi_reg, acc_hi_next;
    logic [XLEN-1:0]  acc_lo_reg, acc_lo_next;
    logic [XLEN-1:0]  opb_reg, opb_next;
    logic [XLEN-1:0]  result_reg, result_next;
    logic [2:0]       op_reg, op_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
    logic [4:0]       rd_reg, rd_next;

    function automatic logic [XLEN-1:0] sel_result(input logic [2:0]        op,
                                                   input logic [2*XLEN-1:0] prod,
                                                   input logic [XLEN-1:0]   quo,
                                                   input logic [XLEN-1:0]   rem);
        logic [XLEN-1:0] r;
        case (op)
            3'b000:                 r = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: r = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         r = quo;
            default:                r = rem;
        endcase
        return r;
    endfunction

    // Command decode on the live EX inputs
    logic            is_div, rs1_signed, rs2_signed, s1, s2;
    logic            div_zero, div_ovf, fast_path, go;
    logic [XLEN-1:0] a_mag, b_mag;

    assign is_div     = funct3[2];
    assign rs1_signed = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
    assign rs2_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    assign s1         = rs1_signed & rs1[XLEN-1];
    assign s2         = rs2_signed & rs2[XLEN-1];
    assign a_mag      = s1 ? (-rs1) : rs1;
    assign b_mag      = s2 ? (-rs2) : rs2;
    assign div_zero   = is_div & (rs2 == '0);
    assign div_ovf    = is_div & ~funct3[0] & (rs1 == MIN_NEG) & (rs2 == '1);
    assign fast_path  = (~is_div & (MUL_ITER == 0)) | div_zero | div_ovf;
    assign go         = start & ~kill;

    // Single-cycle results for the fast path
    logic [2*XLEN-1:0] prod_mag, prod_fast;
    logic [XLEN-1:0]   quo_fast, rem_fast, fast_res;

    assign prod_mag  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign prod_fast = (s1 ^ s2) ? (-prod_mag) : prod_mag;
    assign quo_fast  = div_zero ? '1 : rs1;
    assign rem_fast  = div_zero ? rs1 : '0;
    assign fast_res  = sel_result(funct3, prod_fast, quo_fast, rem_fast);

    // One iteration step: shift-add multiply or restoring divide
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo;
    logic [2*XLEN-1:0] prod_it;
    logic [XLEN-1:0]   quo_it, rem_it, iter_res;

    assign mul_sum  = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : '0);
    assign mul_hi   = mul_sum[XLEN:1];
    assign mul_lo   = {mul_sum[0], acc_lo_reg[XLEN-1:1]};
    assign div_sh   = {acc_hi_reg, acc_lo_reg[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opb_reg};
    assign div_hi   = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
    assign div_lo   = {acc_lo_reg[XLEN-2:0], ~div_diff[XLEN]};
    assign prod_it  = neg_q_reg ? (-{mul_hi, mul_lo}) : {mul_hi, mul_lo};
    assign quo_it   = neg_q_reg ? (-div_lo) : div_lo;
    assign rem_it   = neg_r_reg ? (-div_hi) : div_hi;
    assign iter_res = sel_result(op_reg, prod_it, quo_it, rem_it);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        opb_next    = opb_reg;
        result_next = result_reg;
        op_next     = op_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        rd_next     = rd_reg;
        case (state_reg)
            IDLE: begin
                if (go) begin
                    op_next    = funct3;
                    rd_next    = rd_adr_in;
                    neg_q_next = s1 ^ s2;
                    neg_r_next = s1;
                    if (fast_path) begin
                        result_next = fast_res;
                        state_next  = DONE;
                    end else begin
                        // Divider shifts the dividend out of acc_lo; multiplier shifts the multiplier out
                        acc_hi_next = '0;
                        acc_lo_next = is_div ? a_mag : b_mag;
                        opb_next    = is_div ? b_mag : a_mag;
                        cnt_next    = CNT_W'(XLEN - 1);
                        state_next  = CALC;
                    end
                end
            end
            CALC: begin
                acc_hi_next = op_reg[2] ? div_hi : mul_hi;
                acc_lo_next = op_reg[2] ? div_lo : mul_lo;
                cnt_next    = cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    cnt_next    = '0;
                    result_next = iter_res;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (!hold) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (kill) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            rd_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            opb_reg    <= opb_next;
            result_reg <= result_next;
            op_reg     <= op_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            rd_reg     <= rd_next;
        end
    end

    assign busy       = ~kill & (((state_reg == IDLE) & start & ~fast_path) | (state_reg == CALC));
    assign res_valid  = (state_reg == DONE);
    assign result     = result_reg;
    assign rd_adr_out = rd_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: one combinational-multiply and one iterative-multiply
// instance share stimulus; per-instance monitors check results against a reference model.
module tb_ex_muldiv;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            kill = 1'b0;
    logic            hold = 1'b0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic [4:0]      rd_adr_in = '0;

    logic            busy0, valid0, busy1, valid1;
    logic [XLEN-1:0] result0, result1;
    logic [4:0]      rdo0, rdo1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ex_muldiv #(.XLEN(XLEN), .MUL_ITER(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .rd_adr_in(rd_adr_in), .kill(kill), .hold(hold), .busy(busy0), .res_valid(valid0),
        .result(result0), .rd_adr_out(rdo0));

    ex_muldiv #(.XLEN(XLEN), .MUL_ITER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .rd_adr_in(rd_adr_in), .kill(kill), .hold(hold), .busy(busy1), .res_valid(valid1),
        .result(result1), .rd_adr_out(rdo1));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          issue;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   lat0, lat1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        bit          ovf;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int mul_iter);
        bit fast;
        fast = (f < 3'd4 && mul_iter == 0) || (f >= 3'd4 && b == 0) ||
               ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return fast ? 1 : XLEN + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom();
        endcase
    endfunction

    // Monitors: one pop per rising res_valid
    bit v0_prev = 1'b0;
    bit v1_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) v0_prev = 1'b0;
        else begin
            if (valid0 && !v0_prev) begin
                if (q0.size() == 0) check("dut0_unexpected_valid", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("dut0_result", result0, e.res);
                    check("dut0_rd", rdo0, e.rd);
                    check("dut0_latency", cyc - e.issue, e.lat);
                    $display("dut0 txn: result=%08h rd=%0d lat=%0d", result0, rdo0, cyc - e.issue);
                end
            end
            v0_prev = valid0;
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) v1_prev = 1'b0;
        else begin
            if (valid1 && !v1_prev) begin
                if (q1.size() == 0) check("dut1_unexpected_valid", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("dut1_result", result1, e.res);
                    check("dut1_rd", rdo1, e.rd);
                    check("dut1_latency", cyc - e.issue, e.lat);
                    $display("dut1 txn: result=%08h rd=%0d lat=%0d", result1, rdo1, cyc - e.issue);
                end
            end
            v1_prev = valid1;
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push);
        exp_t e;
        funct3 = f; rs1 = a; rs2 = b; rd_adr_in = rd; start = 1'b1;
        lat0 = ref_lat(f, a, b, 0);
        lat1 = ref_lat(f, a, b, 1);
        if (push) begin
            e.res = ref_res(f, a, b); e.rd = rd; e.issue = cyc;
            e.lat = lat0; q0.push_back(e);
            e.lat = lat1; q1.push_back(e);
        end
        #1;
        check("dut0_busy_at_start", busy0, lat0 != 1);
        check("dut1_busy_at_start", busy1, lat1 != 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen0, seen1;
        int b0, b1;
        seen0 = 0; seen1 = 0; b0 = 0; b1 = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (valid0) seen0 = 1; else if (!seen0 && busy0) b0++;
            if (valid1) seen1 = 1; else if (!seen1 && busy1) b1++;
            if (seen0 && seen1) break;
            @(negedge clk);
        end
        check({tag, "_done"}, {seen0, seen1}, 2'b11);
        check({tag, "_busy_cycles0"}, b0, lat0 - 1);
        check({tag, "_busy_cycles1"}, b1, lat1 - 1);
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string tag);
        issue(f, a, b, rd, 1'b1);
        wait_done(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid0", valid0, 0);
        check("reset_busy0", busy0, 0);
        check("reset_result1", result1, 0);
        check("reset_rd1", rdo1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(3'd0, 32'hFFFF_FFFF, 32'h2, 5'd1, "mul");
        run(3'd1, 32'hFFFF_FFFF, 32'h2, 5'd2, "mulh");
        run(3'd4, 32'hFFFF_FFF9, 32'h2, 5'd3, "div");
        run(3'd6, 32'hFFFF_FFF9, 32'h2, 5'd4, "rem");
        run(3'd5, 32'd100, 32'h0, 5'd5, "divu_zero");
        run(3'd7, 32'd100, 32'h0, 5'd6, "remu_zero");
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, "div_ovf");
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, "rem_ovf");

        // Abort in CALC cycle 10
        issue(3'd5, 32'd1000, 32'd7, 5'd9, 1'b0);
        nv = 0;
        repeat (9) begin
            #1;
            if (valid0 || valid1) nv++;
            @(negedge clk);
        end
        kill = 1'b1;
        @(negedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy0", busy0, 0);
        check("kill_busy1", busy1, 0);
        repeat (40) begin
            @(negedge clk);
            #1;
            if (valid0 || valid1) nv++;
        end
        check("kill_no_valid", nv, 0);
        run(3'd5, 32'd1000, 32'd7, 5'd10, "divu_after_kill");

        // Hold in DONE on the iterative multiplier
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1);
        for (int i = 0; i < 60; i++) begin
            #1;
            if (valid1) break;
            @(negedge clk);
        end
        check("hold_reached_done", valid1, 1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("hold_valid", valid1, 1);
            check("hold_result", result1, 32'hFFFF_FFFE);
        end
        hold = 1'b0;
        @(negedge clk);
        #1;
        check("hold_release", valid1, 0);

        // Asynchronous reset in the middle of CALC
        issue(3'd4, 32'hFFFF_FFF9, 32'h2, 5'd12, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy1", busy1, 0);
        check("arst_valid1", valid1, 0);
        check("arst_result1", result1, 0);
        check("arst_rd1", rdo1, 0);
        check("arst_result0", result0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run(f, a, b, 5'($urandom_range(0, 31)), "random");
        end

        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
